// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse_meter block: FSM state encoding.
package pulse_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HIGH = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_meter_sync.sv
// Input conditioning for pulse_meter: optional SYNC-deep synchronizer plus
// rising-edge detection on the synchronized level.
module pulse_meter_sync #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic ipulse,
    output logic s,
    output logic rise
);

    logic s_prev;

    generate
        if (SYNC == 0) begin : g_pass
            assign s = ipulse;
        end else begin : g_sync
            logic [SYNC-1:0] chain;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    chain <= '0;
                end else begin
                    chain[0] <= ipulse;
                    for (int i = 1; i < SYNC; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign s = chain[SYNC-1];
        end
    endgenerate

    // s_prev resets to 0, so a line already high out of reset reads as a rise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_prev <= 1'b0;
        end else begin
            s_prev <= s;
        end
    end

    assign rise = s & ~s_prev;

endmodule

// File: rtl/pulse_meter.sv
// Pulse receiver: measures cycles from arming to the rising edge (dly) and the
// high width (len) of a single-bit line, reporting each result with a strobe.
module pulse_meter
    import pulse_pkg::*;
#(
    parameter int W    = 16,
    parameter int SYNC = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         arm,
    input  logic         ipulse,
    output logic         valid,
    output logic         busy,
    output logic [W-1:0] dly,
    output logic [W-1:0] len,
    output logic         dly_ovf,
    output logic         len_ovf,
    output state_t       dbg_state
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // valid is a one-cycle strobe with no backpressure; results hold until the next strobe.
    state_t         state, state_d;
    logic [W-1:0]   cnt, cnt_d;
    logic [W-1:0]   dly_d, len_d;
    logic           valid_d, dly_ovf_d, len_ovf_d;
    logic           s, rise;

    pulse_meter_sync #(
        .SYNC(SYNC)
    ) u_sync (
        .clk    (clk),
        .rstn   (rstn),
        .ipulse (ipulse),
        .s      (s),
        .rise   (rise)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_WAIT;
            cnt     <= '0;
            dly     <= '0;
            len     <= '0;
            valid   <= 1'b0;
            dly_ovf <= 1'b0;
            len_ovf <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            dly     <= dly_d;
            len     <= len_d;
            valid   <= valid_d;
            dly_ovf <= dly_ovf_d;
            len_ovf <= len_ovf_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        dly_d     = dly;
        len_d     = len;
        valid_d   = 1'b0;
        dly_ovf_d = dly_ovf;
        len_ovf_d = len_ovf;

        // arm has priority over any completion on the same edge.
        if (arm) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (rise) begin
                        dly_d   = cnt;
                        cnt_d   = W'(1);
                        state_d = ST_HIGH;
                    end else if (cnt == CNT_MAX) begin
                        dly_d     = CNT_MAX;
                        dly_ovf_d = 1'b1;
                        len_d     = '0;
                        len_ovf_d = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        cnt_d = cnt + W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!s) begin
                        len_d     = cnt;
                        len_ovf_d = 1'b0;
                        dly_ovf_d = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = ST_DONE;
                    end else if (cnt == CNT_MAX) begin
                        len_d     = CNT_MAX;
                        len_ovf_d = 1'b1;
                        dly_ovf_d = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        cnt_d = cnt + W'(1);
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign busy      = (state != ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: three instances (SYNC=0/W=16, SYNC=2/W=16, SYNC=0/W=4)
// share one stimulus and are checked against an edge-timestamp model.
module tb_pulse_meter;
    import pulse_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    logic arm;
    logic ipulse;

    logic        v0, b0, do0, lo0;
    logic [15:0] d0, l0;
    state_t      st0;
    logic        v2, b2, do2, lo2;
    logic [15:0] d2, l2;
    state_t      st2;
    logic        v4, b4, do4, lo4;
    logic [3:0]  d4, l4;
    state_t      st4;

    always #5 clk = ~clk;

    pulse_meter #(.W(16), .SYNC(0)) u0 (
        .clk(clk), .rstn(rstn), .arm(arm), .ipulse(ipulse),
        .valid(v0), .busy(b0), .dly(d0), .len(l0),
        .dly_ovf(do0), .len_ovf(lo0), .dbg_state(st0)
    );

    pulse_meter #(.W(16), .SYNC(2)) u2 (
        .clk(clk), .rstn(rstn), .arm(arm), .ipulse(ipulse),
        .valid(v2), .busy(b2), .dly(d2), .len(l2),
        .dly_ovf(do2), .len_ovf(lo2), .dbg_state(st2)
    );

    pulse_meter #(.W(4), .SYNC(0)) u4 (
        .clk(clk), .rstn(rstn), .arm(arm), .ipulse(ipulse),
        .valid(v4), .busy(b4), .dly(d4), .len(l4),
        .dly_ovf(do4), .len_ovf(lo4), .dbg_state(st4)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: per instance, measurement start edge and rise edge timestamps.
    string nm[3]     = '{"u0", "u2", "u4"};
    int    m_sync[3] = '{0, 2, 0};
    int    m_max[3]  = '{65535, 65535, 15};
    int    m_phase[3];   // 0 looking for rise, 1 timing high, 2 reported
    int    m_start[3];
    int    m_rise[3];
    int    e_valid[3], e_dly[3], e_len[3], e_dovf[3], e_lovf[3];
    bit    p_hist[0:511];
    int    k_edge;

    int    n_valid[3] = '{0, 0, 0};
    int    cap_dly[3], cap_len[3], cap_dovf[3], cap_lovf[3];

    function automatic bit s_at(input int i, input int k);
        int idx;
        idx = k - m_sync[i];
        if (k < 1 || idx < 1) return 1'b0;
        return p_hist[idx];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rstn) begin
                k_edge = 0;
                for (int i = 0; i < 3; i++) begin
                    m_phase[i] = 0; m_start[i] = 0; m_rise[i] = 0;
                    e_valid[i] = 0; e_dly[i] = 0; e_len[i] = 0;
                    e_dovf[i] = 0; e_lovf[i] = 0;
                end
            end else begin
                k_edge++;
                p_hist[k_edge] = ipulse;
                for (int i = 0; i < 3; i++) begin
                    e_valid[i] = 0;
                    if (arm) begin
                        m_phase[i] = 0;
                        m_start[i] = k_edge;
                    end else if (m_phase[i] == 0) begin
                        if (s_at(i, k_edge) && !s_at(i, k_edge - 1)) begin
                            m_rise[i]  = k_edge;
                            e_dly[i]   = k_edge - m_start[i] - 1;
                            m_phase[i] = 1;
                        end else if (k_edge - m_start[i] - 1 == m_max[i]) begin
                            e_dly[i] = m_max[i]; e_dovf[i] = 1;
                            e_len[i] = 0;        e_lovf[i] = 0;
                            e_valid[i] = 1;      m_phase[i] = 2;
                        end
                    end else if (m_phase[i] == 1) begin
                        if (!s_at(i, k_edge)) begin
                            e_len[i] = k_edge - m_rise[i];
                            e_lovf[i] = 0; e_dovf[i] = 0;
                            e_valid[i] = 1; m_phase[i] = 2;
                        end else if (k_edge - m_rise[i] == m_max[i]) begin
                            e_len[i] = m_max[i];
                            e_lovf[i] = 1; e_dovf[i] = 0;
                            e_valid[i] = 1; m_phase[i] = 2;
                        end
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    initial begin
        int a_v[3], a_b[3], a_d[3], a_l[3], a_do[3], a_lo[3], a_done[3];
        forever begin
            @(negedge clk);
            a_v  = '{int'(v0), int'(v2), int'(v4)};
            a_b  = '{int'(b0), int'(b2), int'(b4)};
            a_d  = '{int'(d0), int'(d2), int'(d4)};
            a_l  = '{int'(l0), int'(l2), int'(l4)};
            a_do = '{int'(do0), int'(do2), int'(do4)};
            a_lo = '{int'(lo0), int'(lo2), int'(lo4)};
            a_done = '{int'(st0 == ST_DONE), int'(st2 == ST_DONE), int'(st4 == ST_DONE)};
            for (int i = 0; i < 3; i++) begin
                if (!rstn) begin
                    check({nm[i], "_rst_valid"}, a_v[i], 0);
                    check({nm[i], "_rst_busy"}, a_b[i], 1);
                    check({nm[i], "_rst_dly"}, a_d[i], 0);
                    check({nm[i], "_rst_len"}, a_l[i], 0);
                    check({nm[i], "_rst_dovf"}, a_do[i], 0);
                    check({nm[i], "_rst_lovf"}, a_lo[i], 0);
                end else begin
                    check({nm[i], "_valid"}, a_v[i], e_valid[i]);
                    check({nm[i], "_busy"}, a_b[i], int'(m_phase[i] != 2));
                    check({nm[i], "_state_done"}, a_done[i], int'(m_phase[i] == 2));
                    check({nm[i], "_dly"}, a_d[i], e_dly[i]);
                    check({nm[i], "_len"}, a_l[i], e_len[i]);
                    check({nm[i], "_dovf"}, a_do[i], e_dovf[i]);
                    check({nm[i], "_lovf"}, a_lo[i], e_lovf[i]);
                end
                if (a_v[i] == 1) begin
                    n_valid[i]++;
                    cap_dly[i]  = a_d[i];
                    cap_len[i]  = a_l[i];
                    cap_dovf[i] = a_do[i];
                    cap_lovf[i] = a_lo[i];
                end
            end
        end
    end

    task automatic cyc(input bit pv, input bit av);
        ipulse = pv;
        arm    = av;
        @(posedge clk);
        #1;
    endtask

    // Generator equivalent released with the meter: high on edges d+2 .. d+l+1 (l=0: stuck high).
    task automatic gen(input int d, input int l, input int n);
        for (int k = 1; k <= n; k++) begin
            cyc((k >= d + 2) && (l == 0 || k <= d + l + 1), 1'b0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn   = 1'b0;
        ipulse = 1'b0;
        arm    = 1'b0;
        #2;
        check("rst_now_dly0", int'(d0), 0);
        check("rst_now_len0", int'(l0), 0);
        check("rst_now_valid0", int'(v0), 0);
        check("rst_now_busy0", int'(b0), 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("rel_busy0", int'(b0), 1);
    endtask

    initial begin
        int base0, base2, base4;
        rstn   = 1'b1;
        arm    = 1'b0;
        ipulse = 1'b0;
        #1 rstn = 1'b0;

        // dly=8, len=1 generator
        do_reset();
        base0 = n_valid[0]; base2 = n_valid[1]; base4 = n_valid[2];
        gen(8, 1, 30);
        check("s1_count0", n_valid[0] - base0, 1);
        check("s1_dly0", cap_dly[0], 9);
        check("s1_len0", cap_len[0], 1);
        check("s1_dovf0", cap_dovf[0], 0);
        check("s1_lovf0", cap_lovf[0], 0);
        check("s1_count2", n_valid[1] - base2, 1);
        check("s1_dly2", cap_dly[1], 11);
        check("s1_count4", n_valid[2] - base4, 1);
        check("s1_dly4", cap_dly[2], 9);
        check("s1_len4", cap_len[2], 1);

        // dly=0, len=1 generator
        do_reset();
        gen(0, 1, 20);
        check("s2_dly2", cap_dly[1], 3);
        check("s2_len2", cap_len[1], 1);
        check("s2_dly0", cap_dly[0], 1);

        // stuck-high line saturates the 4-bit length counter
        do_reset();
        base4 = n_valid[2];
        gen(8, 0, 30);
        check("s3_count4", n_valid[2] - base4, 1);
        check("s3_dly4", cap_dly[2], 9);
        check("s3_len4", cap_len[2], 15);
        check("s3_lovf4", cap_lovf[2], 1);
        check("s3_dovf4", cap_dovf[2], 0);
        check("s3_busy0", int'(b0), 1);

        // idle line times out the 4-bit delay counter
        do_reset();
        base4 = n_valid[2];
        gen(100, 1, 20);
        check("s4_count4", n_valid[2] - base4, 1);
        check("s4_dly4", cap_dly[2], 15);
        check("s4_dovf4", cap_dovf[2], 1);
        check("s4_len4", cap_len[2], 0);
        check("s4_lovf4", cap_lovf[2], 0);

        // arm aborts mid-high, then re-arm from DONE
        do_reset();
        base0 = n_valid[0];
        for (int k = 1; k <= 35; k++) begin
            cyc((k >= 5 && k <= 9) || (k >= 15 && k <= 17) || (k >= 26 && k <= 27),
                (k == 8) || (k == 22));
            if (k == 20) begin
                check("s5_count0_a", n_valid[0] - base0, 1);
                check("s5_dly0_a", cap_dly[0], 6);
                check("s5_len0_a", cap_len[0], 3);
            end
        end
        check("s5_count0_b", n_valid[0] - base0, 2);
        check("s5_dly0_b", cap_dly[0], 3);
        check("s5_len0_b", cap_len[0], 2);

        // reset dropped mid-high, then a fresh pulse
        do_reset();
        gen(2, 10, 7);
        check("s6_mid_dly0", int'(d0), 3);
        check("s6_mid_high0", int'(st0 == ST_HIGH), 1);
        do_reset();
        gen(3, 2, 15);
        check("s6_dly0", cap_dly[0], 4);
        check("s6_len0", cap_len[0], 2);
        check("s6_dly2", cap_dly[1], 6);
        check("s6_len2", cap_len[1], 2);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
